hyperbus_arbiter: RTL and testbench
===================================

HYPERBUS_ARBITER -- requirements
Module: hyperbus_arbiter

Interface
REQ-001 Parameters SHALL be: HBUS_ADDR_WIDTH, default 32, address width; HBUS_DATA_WIDTH, default 16, data width; TIMEOUT, default 255, stall cycles before forced release (0 disables the watchdog).
REQ-002 The block SHALL use one clock, hbus_clk, and an asynchronous, active-high reset, hbus_rst.
REQ-003 Ports SHALL be, in order:
- hbus_clk  in  1  clock
- hbus_rst  in  1  async active-high reset
- mN_adr_i  in  HBUS_ADDR_WIDTH  requester N address (N = 0, 1)
- mN_dat_i  in  HBUS_DATA_WIDTH  requester N write data
- mN_dat_o  out  HBUS_DATA_WIDTH  read data to requester N
- mN_rrq  in  1  requester N read request
- mN_wrq  in  1  requester N write request
- mN_ready  out  1  write-beat accept to requester N
- mN_valid  out  1  read-beat valid to requester N
- mN_gnt  out  1  requester N owns the bus
- mN_err  out  1  one-cycle watchdog abort pulse to requester N
- hbus_adr_o  out  HBUS_ADDR_WIDTH  address to controller
- hbus_dat_o  out  HBUS_DATA_WIDTH  write data to controller
- hbus_dat_i  in  HBUS_DATA_WIDTH  read data from controller
- hbus_rrq  out  1  read request to controller
- hbus_wrq  out  1  write request to controller
- hbus_ready  in  1  controller accepted a write beat
- hbus_valid  in  1  controller read beat valid
- hbus_busy  in  1  controller transaction in progress

Function
REQ-004 The arbiter SHALL implement one-hot states IDLE, OWN and DRAIN, plus registers owner (1 bit), last (1 bit) and a watchdog counter of width clog2(TIMEOUT+1).
REQ-005 In IDLE with hbus_busy=0, a requester is active when mN_rrq|mN_wrq; the arbiter SHALL latch owner, set mN_gnt=1 on the next edge and enter OWN.
REQ-006 When both requesters are active in the same cycle, the arbiter SHALL grant the one not equal to last (round-robin).
REQ-007 In IDLE with hbus_busy=1, the arbiter SHALL issue no grant and remain in IDLE.
REQ-008 In OWN, the following SHALL be combinational muxes from the owner:
- hbus_adr_o, hbus_dat_o
- hbus_rrq = owner rrq
- hbus_wrq = owner wrq & ~owner rrq (read wins if both are asserted)
REQ-009 Outside OWN, hbus_rrq and hbus_wrq SHALL be 0.
REQ-010 In OWN, owner mN_ready = hbus_ready and owner mN_valid = hbus_valid; the non-owner's ready and valid SHALL be 0 in all states.
REQ-011 m0_dat_o and m1_dat_o SHALL both equal hbus_dat_i at all times (broadcast).
REQ-012 Owner release: in OWN, when owner rrq=0 and wrq=0, the arbiter SHALL next-edge clear mN_gnt, set last=owner and enter DRAIN.
REQ-013 A request toggling mid-grant (rrq and wrq both low for one cycle) SHALL end the grant; no re-grant occurs without passing through DRAIN and IDLE.
REQ-014 DRAIN SHALL hold until hbus_busy=0, then go to IDLE; the earliest next grant is one cycle after leaving DRAIN.
REQ-015 Watchdog counter rules:
- cleared on entry to OWN and on any cycle with hbus_ready|hbus_valid
- otherwise incremented while in OWN
- saturates at TIMEOUT
REQ-016 When the watchdog counter reaches TIMEOUT (TIMEOUT≠0), the arbiter SHALL pulse the owner's mN_err for 1 cycle, clear mN_gnt, set last=owner and enter DRAIN regardless of the owner's request.
REQ-017 After a watchdog abort, that requester SHALL NOT be granted again until it has deasserted both rrq and wrq for at least 1 cycle; a per-requester block flag is set on abort and cleared when the requester goes idle.
REQ-018 Grant-to-first-forwarded-request latency SHALL be 1 cycle: request seen in IDLE at edge k gives gnt and hbus_rrq/hbus_wrq high after edge k+1.

Reset
REQ-019 While hbus_rst=1, regardless of mid-transaction activity, the arbiter SHALL force state=IDLE, owner=0, last=1 (m0 has first priority), watchdog counter=0, block flags=0, and all mN_gnt, mN_err, hbus_rrq and hbus_wrq to 0.
REQ-020 mN_ready and mN_valid SHALL be 0 during reset.
REQ-021 The first grant after reset deassertion SHALL be no earlier than the second clock edge after deassertion.

Verification
REQ-022 m0_rrq only, hbus_busy=0 -> m0_gnt=1 one cycle later; hbus_rrq=1, hbus_adr_o=m0_adr_i; 2 hbus_valid pulses appear on m0_valid only; m0_rrq drop -> DRAIN -> IDLE once busy=0.
REQ-023 m0_wrq and m1_wrq asserted together after reset -> m0 granted first; after m0 releases and busy falls, m1 granted; a third simultaneous round -> m0 again.
REQ-024 m1_wrq asserted, hbus_busy=1 held for 5 cycles -> no grant for 5 cycles; grant one cycle after busy=0.
REQ-025 TIMEOUT=4, m0_rrq held, no valid -> m0_err pulses on the 4th stall cycle, m0_gnt=0, hbus_rrq=0; m0 not regranted until m0_rrq is dropped, while a pending m1 is granted meanwhile.
REQ-026 hbus_rst asserted during OWN with m1 owning -> hbus_rrq, hbus_wrq and m1_gnt go 0 immediately; after release, simultaneous requests grant m0 first.
REQ-027 m0 asserts rrq and wrq together -> hbus_rrq=1 and hbus_wrq=0 throughout the grant.

Source files
------------

// File: rtl/hyperbus_arbiter.sv
// Two-requester HyperBus arbiter.
// Round-robin grant on an idle controller, combinational forwarding of the
// owner's request and data, and a stall watchdog that forcibly releases an
// owner that sees no ready/valid beat for TIMEOUT cycles.
module hyperbus_arbiter #(
  parameter int HBUS_ADDR_WIDTH = 32,
  parameter int HBUS_DATA_WIDTH = 16,
  parameter int TIMEOUT         = 255
) (
  input  logic                       hbus_clk,
  input  logic                       hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0] m0_dat_i,
  output logic [HBUS_DATA_WIDTH-1:0] m0_dat_o,
  input  logic                       m0_rrq,
  input  logic                       m0_wrq,
  output logic                       m0_ready,
  output logic                       m0_valid,
  output logic                       m0_gnt,
  output logic                       m0_err,
  input  logic [HBUS_ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0] m1_dat_i,
  output logic [HBUS_DATA_WIDTH-1:0] m1_dat_o,
  input  logic                       m1_rrq,
  input  logic                       m1_wrq,
  output logic                       m1_ready,
  output logic                       m1_valid,
  output logic                       m1_gnt,
  output logic                       m1_err,
  output logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_o,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  output logic                       hbus_rrq,
  output logic                       hbus_wrq,
  input  logic                       hbus_ready,
  input  logic                       hbus_valid,
  input  logic                       hbus_busy
);

  // A zero TIMEOUT still needs a legal one-bit counter; the watchdog is then disabled.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : WD_W'(0);
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    OWN   = 3'b010,
    DRAIN = 3'b100
  } state_t;

  state_t          state_r;
  logic            owner_r;
  logic            last_r;
  logic [WD_W-1:0] wd_cnt_r;
  logic [1:0]      blk_r;
  logic            armed_r;   // low for the first edge after reset so no grant lands on it
  logic [1:0]      gnt_r;
  logic [1:0]      err_r;

  logic [1:0]      act_s;
  logic            pick_s;
  logic            own_rrq_s;
  logic            own_wrq_s;
  logic            in_own_s;
  logic            beat_s;
  logic            abort_s;

  // Requester qualification, round-robin pick and owner request selection.
  always_comb begin
    act_s[0]  = (m0_rrq | m0_wrq) & ~blk_r[0];
    act_s[1]  = (m1_rrq | m1_wrq) & ~blk_r[1];
    pick_s    = 1'b0;
    if (act_s[0] && act_s[1]) begin
      pick_s = ~last_r;
    end else if (act_s[1]) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    own_rrq_s = owner_r ? m1_rrq : m0_rrq;
    own_wrq_s = owner_r ? m1_wrq : m0_wrq;
    in_own_s  = (state_r == OWN);
    beat_s    = hbus_ready | hbus_valid;
    // Abort on the edge where the stall count would reach TIMEOUT.
    abort_s   = WD_EN && in_own_s && !beat_s && (wd_cnt_r == WD_LAST);
  end

  // Bus forwarding from the owner; everything is gated off outside OWN.
  always_comb begin
    hbus_adr_o = owner_r ? m1_adr_i : m0_adr_i;
    hbus_dat_o = owner_r ? m1_dat_i : m0_dat_i;
    hbus_rrq   = in_own_s & own_rrq_s;
    hbus_wrq   = in_own_s & own_wrq_s & ~own_rrq_s;
    m0_ready   = in_own_s & ~owner_r & hbus_ready;
    m0_valid   = in_own_s & ~owner_r & hbus_valid;
    m1_ready   = in_own_s &  owner_r & hbus_ready;
    m1_valid   = in_own_s &  owner_r & hbus_valid;
    m0_dat_o   = hbus_dat_i;
    m1_dat_o   = hbus_dat_i;
  end

  assign m0_gnt = gnt_r[0];
  assign m1_gnt = gnt_r[1];
  assign m0_err = err_r[0];
  assign m1_err = err_r[1];

  // Arbitration FSM with watchdog, block flags and registered grant/error outputs.
  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
      wd_cnt_r <= WD_W'(0);
      blk_r    <= 2'b00;
      armed_r  <= 1'b0;
      gnt_r    <= 2'b00;
      err_r    <= 2'b00;
    end else begin
      armed_r <= 1'b1;
      err_r   <= 2'b00;

      // A block flag is set by an abort and cleared once its requester goes idle.
      if (abort_s && !owner_r) begin
        blk_r[0] <= 1'b1;
      end else if (!m0_rrq && !m0_wrq) begin
        blk_r[0] <= 1'b0;
      end else begin
        blk_r[0] <= blk_r[0];
      end
      if (abort_s && owner_r) begin
        blk_r[1] <= 1'b1;
      end else if (!m1_rrq && !m1_wrq) begin
        blk_r[1] <= 1'b0;
      end else begin
        blk_r[1] <= blk_r[1];
      end

      case (state_r)
        IDLE: begin
          if (armed_r && !hbus_busy && (act_s != 2'b00)) begin
            owner_r  <= pick_s;
            gnt_r    <= pick_s ? 2'b10 : 2'b01;
            wd_cnt_r <= WD_W'(0);
            state_r  <= OWN;
          end else begin
            state_r  <= IDLE;
          end
        end
        OWN: begin
          if (abort_s) begin
            err_r    <= owner_r ? 2'b10 : 2'b01;
            gnt_r    <= 2'b00;
            last_r   <= owner_r;
            wd_cnt_r <= WD_MAX;
            state_r  <= DRAIN;
          end else if (!own_rrq_s && !own_wrq_s) begin
            gnt_r    <= 2'b00;
            last_r   <= owner_r;
            state_r  <= DRAIN;
          end else if (beat_s) begin
            wd_cnt_r <= WD_W'(0);
          end else if (wd_cnt_r != WD_MAX) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
          end else begin
            wd_cnt_r <= wd_cnt_r;
          end
        end
        DRAIN: begin
          if (!hbus_busy) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          gnt_r   <= 2'b00;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_arbiter.sv
// Directed testbench for hyperbus_arbiter (TIMEOUT = 4).
module tb_hyperbus_arbiter;

  logic        hbus_clk = 1'b0;
  logic        hbus_rst = 1'b1;
  logic [31:0] m0_adr_i = 32'h0, m1_adr_i = 32'h0;
  logic [15:0] m0_dat_i = 16'h0, m1_dat_i = 16'h0;
  logic [15:0] m0_dat_o, m1_dat_o;
  logic        m0_rrq = 1'b0, m0_wrq = 1'b0, m1_rrq = 1'b0, m1_wrq = 1'b0;
  logic        m0_ready, m0_valid, m0_gnt, m0_err;
  logic        m1_ready, m1_valid, m1_gnt, m1_err;
  logic [31:0] hbus_adr_o;
  logic [15:0] hbus_dat_o;
  logic [15:0] hbus_dat_i = 16'h0;
  logic        hbus_rrq, hbus_wrq;
  logic        hbus_ready = 1'b0, hbus_valid = 1'b0, hbus_busy = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  hyperbus_arbiter #(
    .HBUS_ADDR_WIDTH(32),
    .HBUS_DATA_WIDTH(16),
    .TIMEOUT(4)
  ) dut (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_rrq(m0_rrq), .m0_wrq(m0_wrq), .m0_ready(m0_ready), .m0_valid(m0_valid),
    .m0_gnt(m0_gnt), .m0_err(m0_err),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_rrq(m1_rrq), .m1_wrq(m1_wrq), .m1_ready(m1_ready), .m1_valid(m1_valid),
    .m1_gnt(m1_gnt), .m1_err(m1_err),
    .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o), .hbus_dat_i(hbus_dat_i),
    .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq), .hbus_ready(hbus_ready),
    .hbus_valid(hbus_valid), .hbus_busy(hbus_busy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 hbus_clk = ~hbus_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge hbus_clk);
    #1;
  endtask

  initial begin
    // ---- reset with activity on the inputs ----
    m0_rrq = 1'b1; m1_rrq = 1'b1; hbus_valid = 1'b1; hbus_ready = 1'b1;
    tick(); tick();
    check_val("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    check_val("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
    check_val("rst_hbus_rrq", {31'b0, hbus_rrq}, 32'd0);
    check_val("rst_m0_valid", {31'b0, m0_valid}, 32'd0);
    check_val("rst_m1_ready", {31'b0, m1_ready}, 32'd0);
    check_val("rst_m0_err", {31'b0, m0_err}, 32'd0);
    hbus_valid = 1'b0;

    // ---- round robin: m0, m1, m0 (hbus_ready held so no watchdog) ----
    m0_rrq = 1'b0; m1_rrq = 1'b0;
    m0_wrq = 1'b1; m1_wrq = 1'b1;
    m0_adr_i = 32'hA000_0000; m0_dat_i = 16'h00A0;
    m1_adr_i = 32'hB000_0000; m1_dat_i = 16'h00B0;
    hbus_rst = 1'b0;
    tick();
    check_val("rr_first_edge_no_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    check_val("rr1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
    check_val("rr1_wrq", {31'b0, hbus_wrq}, 32'd1);
    check_val("rr1_adr", hbus_adr_o, 32'hA000_0000);
    check_val("rr1_dat", {16'b0, hbus_dat_o}, 32'h0000_00A0);
    check_val("rr1_ready", {30'b0, m1_ready, m0_ready}, 32'd1);
    m0_wrq = 1'b0;
    #1;
    check_val("rr1_drop_wrq", {31'b0, hbus_wrq}, 32'd0);
    tick();
    check_val("rr1_release", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    check_val("rr_idle_gap", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    check_val("rr2_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
    check_val("rr2_adr", hbus_adr_o, 32'hB000_0000);
    check_val("rr2_ready", {30'b0, m1_ready, m0_ready}, 32'd2);
    m1_wrq = 1'b0; m0_wrq = 1'b1;
    tick();
    m1_wrq = 1'b1;
    tick(); tick();
    check_val("rr3_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
    m0_wrq = 1'b0; m1_wrq = 1'b0; hbus_ready = 1'b0;
    tick(); tick();

    // ---- m0 read, two valid beats, broadcast data ----
    m0_rrq = 1'b1; m0_adr_i = 32'h1234_5678;
    tick();
    check_val("rd_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
    check_val("rd_rrq", {31'b0, hbus_rrq}, 32'd1);
    check_val("rd_wrq", {31'b0, hbus_wrq}, 32'd0);
    check_val("rd_adr", hbus_adr_o, 32'h1234_5678);
    hbus_valid = 1'b1; hbus_dat_i = 16'hBEEF;
    #1;
    check_val("rd_beat1", {30'b0, m1_valid, m0_valid}, 32'd1);
    check_val("rd_bcast0", {16'b0, m0_dat_o}, 32'h0000_BEEF);
    check_val("rd_bcast1", {16'b0, m1_dat_o}, 32'h0000_BEEF);
    tick();
    hbus_valid = 1'b0;
    #1;
    check_val("rd_gap", {30'b0, m1_valid, m0_valid}, 32'd0);
    tick();
    hbus_valid = 1'b1; hbus_dat_i = 16'hCAFE;
    #1;
    check_val("rd_beat2", {30'b0, m1_valid, m0_valid}, 32'd1);
    tick();
    hbus_valid = 1'b0; m0_rrq = 1'b0; hbus_busy = 1'b1; m1_wrq = 1'b1;
    tick();
    check_val("rd_release", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    check_val("drain_hold", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    m1_wrq = 1'b0; hbus_busy = 1'b0;
    tick(); tick();

    // ---- busy blocks grant for 5 cycles ----
    m1_wrq = 1'b1; hbus_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("busy_no_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    end
    hbus_busy = 1'b0;
    tick();
    check_val("busy_then_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
    m1_wrq = 1'b0;
    tick(); tick();

    // ---- read wins when rrq and wrq are both set ----
    m0_rrq = 1'b1; m0_wrq = 1'b1;
    tick();
    check_val("rw_rrq", {31'b0, hbus_rrq}, 32'd1);
    check_val("rw_wrq", {31'b0, hbus_wrq}, 32'd0);
    tick();
    check_val("rw_rrq2", {31'b0, hbus_rrq}, 32'd1);
    check_val("rw_wrq2", {31'b0, hbus_wrq}, 32'd0);
    m0_rrq = 1'b0; m0_wrq = 1'b0;
    tick(); tick();

    // ---- watchdog abort (TIMEOUT = 4) ----
    m0_rrq = 1'b1;
    tick();
    check_val("wd_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
    m1_rrq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("wd_stall_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd1);
      check_val("wd_stall_err", {30'b0, m1_err, m0_err}, 32'd0);
    end
    tick();
    check_val("wd_err", {30'b0, m1_err, m0_err}, 32'd1);
    check_val("wd_gnt_off", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    check_val("wd_rrq_off", {31'b0, hbus_rrq}, 32'd0);
    tick();
    check_val("wd_err_pulse", {30'b0, m1_err, m0_err}, 32'd0);
    tick();
    check_val("wd_m1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
    m1_rrq = 1'b0;
    tick(); tick(); tick();
    check_val("wd_m0_blocked", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    m0_rrq = 1'b0;
    tick();
    m0_rrq = 1'b1;
    tick();
    check_val("wd_m0_regrant", {30'b0, m1_gnt, m0_gnt}, 32'd1);
    m0_rrq = 1'b0;
    tick(); tick();

    // ---- reset while m1 owns ----
    m1_wrq = 1'b1; hbus_ready = 1'b1;
    tick();
    check_val("ro_m1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd2);
    check_val("ro_wrq", {31'b0, hbus_wrq}, 32'd1);
    hbus_rst = 1'b1;
    #1;
    check_val("ro_rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    check_val("ro_rst_wrq", {31'b0, hbus_wrq}, 32'd0);
    check_val("ro_rst_rrq", {31'b0, hbus_rrq}, 32'd0);
    check_val("ro_rst_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
    tick();
    m0_wrq = 1'b1;
    hbus_rst = 1'b0;
    tick();
    check_val("ro_first_edge", {30'b0, m1_gnt, m0_gnt}, 32'd0);
    tick();
    check_val("ro_m0_first", {30'b0, m1_gnt, m0_gnt}, 32'd1);
    m0_wrq = 1'b0; m1_wrq = 1'b0; hbus_ready = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
